// File: rtl/pulse_period_meter_pkg.sv
// Shared types and constants for the pulse period meter.
package pulse_period_meter_pkg;

    typedef enum logic {IDLE, COUNT} ppm_state_t;

    localparam int PPM_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs; synchronous active-high reset.
import pulse_period_meter_pkg::*;

module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [PPM_SYNC_STAGES-1:0] sync_chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[PPM_SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_chain[PPM_SYNC_STAGES-1];

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of pulse_in, with timeout.
// Define PULSE_PERIOD_METER_SYNC_EN to pass pulse_in through a two-flop synchronizer.
import pulse_period_meter_pkg::*;

module pulse_period_meter #(
    parameter int WIDTH     = 17,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    if (MAX_COUNT < 2 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max_count
        $error("pulse_period_meter: MAX_COUNT out of range 2 .. 2**WIDTH-1");
    end

    logic p;
    logic p_q;
    logic rise;

`ifdef PULSE_PERIOD_METER_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .q     (p)
    );
`else
    assign p = pulse_in;
`endif

    // Edge history runs regardless of enable so a level held through a disable is not a new rise
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p;
        end
    end

    assign rise = p & ~p_q;

    ppm_state_t       state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             busy_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            period  <= period_nxt;
            valid   <= valid_nxt;
            timeout <= timeout_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        period_nxt  = period;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = COUNT;
                        count_nxt = ONE;
                    end else begin
                        count_nxt = '0;
                    end
                end
                COUNT: begin
                    // A rise coinciding with the bound is still a valid measurement
                    if (rise) begin
                        period_nxt = count;
                        valid_nxt  = 1'b1;
                        count_nxt  = ONE;
                    end else if (count == MAX_CNT) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                        count_nxt   = '0;
                    end else begin
                        count_nxt = count + ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end

        busy_nxt = (state_nxt == COUNT);
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed self-checking bench for pulse_period_meter (default and MAX_COUNT=50 instances).
module tb_pulse_period_meter;

    localparam int W = 17;
`ifdef PULSE_PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         pulse_in;

    logic [W-1:0] a_period, b_period;
    logic         a_valid, a_timeout, a_busy;
    logic         b_valid, b_timeout, b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.WIDTH(W)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pulse_in (pulse_in),
        .period   (a_period),
        .valid    (a_valid),
        .timeout  (a_timeout),
        .busy     (a_busy)
    );

    pulse_period_meter #(.WIDTH(W), .MAX_COUNT(50)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .pulse_in (pulse_in),
        .period   (b_period),
        .valid    (b_valid),
        .timeout  (b_timeout),
        .busy     (b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        pulse_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One-cycle pulse, then idle so the next pulse lands exactly gap edges later
    task automatic pulse_gap(input int gap, input logic exp_v, input int exp_p,
                             input logic exp_busy, input logic sel_b);
        logic         v, t, bz;
        logic [W-1:0] p;
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        repeat (LAT) tick();
        v  = sel_b ? b_valid   : a_valid;
        t  = sel_b ? b_timeout : a_timeout;
        bz = sel_b ? b_busy    : a_busy;
        p  = sel_b ? b_period  : a_period;
        check_eq("valid_on", {31'd0, v}, {31'd0, exp_v});
        if (exp_v) check_eq("period", {15'd0, p}, exp_p);
        check_eq("busy", {31'd0, bz}, {31'd0, exp_busy});
        check_eq("timeout_quiet", {31'd0, t}, 32'd0);
        tick();
        v = sel_b ? b_valid : a_valid;
        check_eq("valid_off", {31'd0, v}, 32'd0);
        repeat (gap - 2 - LAT) tick();
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        pulse_in = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_a_period",  {15'd0, a_period}, 32'd0);
        check_eq("rst_a_valid",   {31'd0, a_valid},   32'd0);
        check_eq("rst_a_timeout", {31'd0, a_timeout}, 32'd0);
        check_eq("rst_a_busy",    {31'd0, a_busy},    32'd0);
        check_eq("rst_b_period",  {15'd0, b_period}, 32'd0);
        check_eq("rst_b_busy",    {31'd0, b_busy},    32'd0);

        // Pulses every 100 cycles
        enable = 1'b1;
        pulse_gap(100, 1'b0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) pulse_gap(100, 1'b1, 100, 1'b1, 1'b0);

        // Timeout with MAX_COUNT=50, single pulse
        do_reset();
        enable   = 1'b1;
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        repeat (LAT) tick();
        check_eq("b_busy_armed", {31'd0, b_busy}, 32'd1);
        repeat (49) tick();
        check_eq("b_timeout_early", {31'd0, b_timeout}, 32'd0);
        check_eq("b_busy_before_to", {31'd0, b_busy}, 32'd1);
        tick();
        check_eq("b_timeout_on", {31'd0, b_timeout}, 32'd1);
        check_eq("b_busy_after_to", {31'd0, b_busy}, 32'd0);
        check_eq("b_period_held", {15'd0, b_period}, 32'd0);
        check_eq("b_valid_at_to", {31'd0, b_valid}, 32'd0);
        tick();
        check_eq("b_timeout_off", {31'd0, b_timeout}, 32'd0);

        // Second rise exactly at the bound: measurement wins
        do_reset();
        enable = 1'b1;
        pulse_gap(50, 1'b0, 0, 1'b1, 1'b1);
        pulse_gap(50, 1'b1, 50, 1'b1, 1'b1);

        // Enable dropped mid-measurement, then restarted
        do_reset();
        enable = 1'b1;
        pulse_gap(30, 1'b0, 0, 1'b1, 1'b0);
        enable = 1'b0;
        tick();
        check_eq("abort_busy", {31'd0, a_busy}, 32'd0);
        check_eq("abort_valid", {31'd0, a_valid}, 32'd0);
        check_eq("abort_timeout", {31'd0, a_timeout}, 32'd0);
        pulse_gap(40, 1'b0, 0, 1'b0, 1'b0);
        enable = 1'b1;
        pulse_gap(40, 1'b0, 0, 1'b1, 1'b0);
        pulse_gap(40, 1'b1, 40, 1'b1, 1'b0);
        pulse_gap(40, 1'b1, 40, 1'b1, 1'b0);

        // Reset mid-count after a latched result
        do_reset();
        enable = 1'b1;
        pulse_gap(100, 1'b0, 0, 1'b1, 1'b0);
        pulse_gap(100, 1'b1, 100, 1'b1, 1'b0);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_period",  {15'd0, a_period}, 32'd0);
        check_eq("mid_rst_valid",   {31'd0, a_valid},   32'd0);
        check_eq("mid_rst_timeout", {31'd0, a_timeout}, 32'd0);
        check_eq("mid_rst_busy",    {31'd0, a_busy},    32'd0);
        pulse_gap(100, 1'b0, 0, 1'b1, 1'b0);
        pulse_gap(100, 1'b1, 100, 1'b1, 1'b0);

        // High for 30 cycles (one arming rise), then 1010...: first result 31, then 2
        do_reset();
        enable = 1'b1;
        for (int j = 0; j <= 30 + 16 + LAT + 1; j++) begin
            int   idx;
            logic exp_v;
            if (j < 30)      pulse_in = 1'b1;
            else if (j < 46) pulse_in = ((j - 30) % 2) == 1;
            else             pulse_in = 1'b0;
            tick();
            idx   = j - LAT;
            exp_v = (idx >= 31) && (idx <= 45) && ((idx % 2) == 1);
            check_eq("toggle_valid", {31'd0, a_valid}, {31'd0, exp_v});
            if (exp_v) check_eq("toggle_period", {15'd0, a_period}, (idx == 31) ? 32'd31 : 32'd2);
            if (j == LAT) check_eq("toggle_busy", {31'd0, a_busy}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
